// File: rtl/commu_pkg.sv
// Shared definitions for the commu serial link: frame header bytes and receiver state encodings.
// Used by both the receive deframer and the transmit side so header bytes stay consistent.
package commu_pkg;

    localparam logic [7:0] HDR0 = 8'hEB;
    localparam logic [7:0] HDR1 = 8'h90;

    typedef enum logic [2:0] {
        HUNT,
        H2,
        ID,
        LENH,
        LENL,
        DATA,
        SUM
    } frm_state_t;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_BITS,
        U_STOP
    } uart_state_t;

    function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/commu_uart_rx.sv
// 8N1 UART receiver, 16x oversampled: 2-FF synchroniser, free-running 1/16-bit tick and
// mid-bit sampler producing rx_byte/byte_vld, or err_stop when the stop bit reads low.
module commu_uart_rx
    import commu_pkg::*;
#(
    parameter int BAUD_DIV = 27
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_a,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       err_stop
);

    localparam int TW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(BAUD_DIV - 1);

    logic          rx_s1, rx_s2, rx_d;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic          fall;

    uart_state_t   ust, ust_nx;
    logic [3:0]    sub_cnt, sub_nx;
    logic [2:0]    bit_idx, bit_nx;
    logic [7:0]    shreg, sh_nx;
    logic          vld_nx, serr_nx;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_d     <= 1'b1;
            tick_cnt <= '0;
        end else begin
            rx_s1    <= rx_a;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            tick_cnt <= (tick_cnt == TICK_MAX) ? '0 : tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_MAX);
    assign fall = rx_d & ~rx_s2;

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            ust      <= U_IDLE;
            sub_cnt  <= '0;
            bit_idx  <= '0;
            byte_vld <= 1'b0;
            err_stop <= 1'b0;
        end else begin
            ust      <= ust_nx;
            sub_cnt  <= sub_nx;
            bit_idx  <= bit_nx;
            byte_vld <= vld_nx;
            err_stop <= serr_nx;
        end
    end

    always_ff @(posedge clk_sys) begin
        shreg <= sh_nx;
    end

    // Start bit is confirmed at its 8th tick (mid-bit); every later sample is 16 ticks apart.
    always_comb begin
        ust_nx  = ust;
        sub_nx  = sub_cnt;
        bit_nx  = bit_idx;
        sh_nx   = shreg;
        vld_nx  = 1'b0;
        serr_nx = 1'b0;
        case (ust)
            U_IDLE: begin
                if (fall) begin
                    ust_nx = U_START;
                    sub_nx = '0;
                end
            end
            U_START: begin
                if (tick) begin
                    if (sub_cnt == 4'd7) begin
                        sub_nx = '0;
                        bit_nx = '0;
                        ust_nx = rx_s2 ? U_IDLE : U_BITS;
                    end else begin
                        sub_nx = sub_cnt + 4'd1;
                    end
                end
            end
            U_BITS: begin
                if (tick) begin
                    if (sub_cnt == 4'd15) begin
                        sub_nx = '0;
                        sh_nx  = {rx_s2, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            ust_nx = U_STOP;
                        end else begin
                            bit_nx = bit_idx + 3'd1;
                        end
                    end else begin
                        sub_nx = sub_cnt + 4'd1;
                    end
                end
            end
            U_STOP: begin
                if (tick) begin
                    if (sub_cnt == 4'd15) begin
                        sub_nx  = '0;
                        vld_nx  = rx_s2;
                        serr_nx = ~rx_s2;
                        ust_nx  = U_IDLE;
                    end else begin
                        sub_nx = sub_cnt + 4'd1;
                    end
                end
            end
            default: ust_nx = U_IDLE;
        endcase
    end

    assign rx_byte = shreg;

endmodule

// File: rtl/commu_rx.sv
// commu link receiver: UART byte recovery plus packet deframer (EB 90 | ID | LEN | payload | SUM).
// Optional inter-byte timeout is built when COMMU_RX_TMO_EN is defined.
module commu_rx
    import commu_pkg::*;
#(
    parameter int          BAUD_DIV = 27,
    parameter logic [15:0] MAX_LEN  = 16'd2048,
    parameter logic [23:0] TMO_CYC  = 24'd500000
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic       rx_a,
    input  logic [7:0] dev_id,
    output logic [7:0] pk_data,
    output logic       pk_vld,
    output logic       pk_frm,
    output logic       pk_ok,
    output logic       pk_err,
    output logic       err_stop
);

    logic [7:0]  u_byte;
    logic        u_vld;
    logic        u_err_stop;

    frm_state_t  state, state_nx;
    logic [7:0]  sum_acc, sum_nx;
    logic [15:0] byte_cnt, cnt_nx;
    logic [7:0]  len_h, len_h_nx;
    logic [15:0] len_w;
    logic [7:0]  data_p0;
    logic        vld_p0, frm_p0, ok_p0, err_p0;
    logic        tmo_hit;

    commu_uart_rx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clk_sys (clk_sys),
        .rst     (rst),
        .rx_a    (rx_a),
        .rx_byte (u_byte),
        .byte_vld(u_vld),
        .err_stop(u_err_stop)
    );

`ifdef COMMU_RX_TMO_EN
    logic [23:0] tmo_cnt;

    // Counter holds cycles since the last byte; it only runs while a frame is in progress.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (u_vld) begin
            tmo_cnt <= 24'd1;
        end else if (state == HUNT) begin
            tmo_cnt <= '0;
        end else if (!tmo_hit) begin
            tmo_cnt <= tmo_cnt + 24'd1;
        end
    end

    assign tmo_hit = (state != HUNT) && (tmo_cnt == TMO_CYC - 24'd1);
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign tmo_hit    = 1'b0;
`endif

    assign len_w = {len_h, u_byte};

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= HUNT;
            sum_acc  <= '0;
            byte_cnt <= '0;
            len_h    <= '0;
        end else begin
            state    <= state_nx;
            sum_acc  <= sum_nx;
            byte_cnt <= cnt_nx;
            len_h    <= len_h_nx;
        end
    end

    // Deframer: stop-bit errors take priority over bytes, which take priority over timeout.
    always_comb begin
        state_nx = state;
        sum_nx   = sum_acc;
        cnt_nx   = byte_cnt;
        len_h_nx = len_h;
        data_p0  = pk_data;
        vld_p0   = 1'b0;
        frm_p0   = pk_frm;
        ok_p0    = 1'b0;
        err_p0   = 1'b0;
        if (u_err_stop) begin
            if (state != HUNT) begin
                err_p0   = 1'b1;
                frm_p0   = 1'b0;
                state_nx = HUNT;
            end
        end else if (u_vld) begin
            case (state)
                HUNT: begin
                    if (u_byte == HDR0) state_nx = H2;
                end
                H2: begin
                    if (u_byte == HDR1)      state_nx = ID;
                    else if (u_byte != HDR0) state_nx = HUNT;
                end
                ID: begin
                    if (u_byte == dev_id) begin
                        sum_nx   = u_byte;
                        state_nx = LENH;
                    end else begin
                        state_nx = HUNT;
                    end
                end
                LENH: begin
                    len_h_nx = u_byte;
                    sum_nx   = sum_add(sum_acc, u_byte);
                    state_nx = LENL;
                end
                LENL: begin
                    sum_nx = sum_add(sum_acc, u_byte);
                    cnt_nx = len_w;
                    if (len_w == 16'd0) begin
                        state_nx = SUM;
                    end else if (len_w > MAX_LEN) begin
                        err_p0   = 1'b1;
                        state_nx = HUNT;
                    end else begin
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    data_p0 = u_byte;
                    vld_p0  = 1'b1;
                    frm_p0  = 1'b1;
                    sum_nx  = sum_add(sum_acc, u_byte);
                    cnt_nx  = byte_cnt - 16'd1;
                    if (byte_cnt == 16'd1) state_nx = SUM;
                end
                SUM: begin
                    ok_p0    = (u_byte == sum_acc);
                    err_p0   = (u_byte != sum_acc);
                    frm_p0   = 1'b0;
                    state_nx = HUNT;
                end
                default: state_nx = HUNT;
            endcase
        end else if (tmo_hit) begin
            err_p0   = 1'b1;
            frm_p0   = 1'b0;
            state_nx = HUNT;
        end
    end

    // Output stage: one clock after the UART byte strobe.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            pk_data  <= '0;
            pk_vld   <= 1'b0;
            pk_frm   <= 1'b0;
            pk_ok    <= 1'b0;
            pk_err   <= 1'b0;
            err_stop <= 1'b0;
        end else begin
            pk_data  <= data_p0;
            pk_vld   <= vld_p0;
            pk_frm   <= frm_p0;
            pk_ok    <= ok_p0;
            pk_err   <= err_p0;
            err_stop <= u_err_stop;
        end
    end

endmodule

// File: tb/tb_commu_rx.sv
// Bench for commu_rx: UART line driver, queue-based frame model and per-cycle output compare.
module tb_commu_rx;

    localparam int          BD   = 2;
    localparam int          BIT  = 16 * BD;
    localparam logic [15:0] MAXL = 16'd2048;
    localparam logic [23:0] TMO  = 24'd1000;

    localparam int K_DATA = 0;
    localparam int K_OK   = 1;
    localparam int K_ERR  = 2;
    localparam int K_STOP = 3;

    logic       clk_sys = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_a    = 1'b1;
    logic [7:0] dev_id  = 8'h05;
    logic [7:0] pk_data;
    logic       pk_vld, pk_frm, pk_ok, pk_err, err_stop;

    always #5 clk_sys = ~clk_sys;

    commu_rx #(
        .BAUD_DIV(BD),
        .MAX_LEN (MAXL),
        .TMO_CYC (TMO)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .rx_a    (rx_a),
        .dev_id  (dev_id),
        .pk_data (pk_data),
        .pk_vld  (pk_vld),
        .pk_frm  (pk_frm),
        .pk_ok   (pk_ok),
        .pk_err  (pk_err),
        .err_stop(err_stop)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         kind;
        logic [7:0] val;
    } ev_t;

    ev_t        expq[$];
    logic [7:0] pend[$];

    task automatic push_ev(input int k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        expq.push_back(e);
    endtask

    // pend holds the bytes of the frame being collected; empty means hunting for a header.
    task automatic model_byte(input logic [7:0] b);
        int         n;
        int         len;
        logic [7:0] s;
        pend.push_back(b);
        n = pend.size();
        if (pend[0] != 8'hEB) begin
            pend.delete();
            return;
        end
        if (n == 2) begin
            if (b == 8'hEB)      void'(pend.pop_front());
            else if (b != 8'h90) pend.delete();
            return;
        end
        if (n == 3) begin
            if (b != dev_id) pend.delete();
            return;
        end
        if (n < 5) return;
        len = int'({pend[3], pend[4]});
        if (n == 5) begin
            if (len > int'(MAXL)) begin
                push_ev(K_ERR, 8'h00);
                pend.delete();
            end
            return;
        end
        if (n <= 5 + len) begin
            push_ev(K_DATA, b);
        end else begin
            s = 8'h00;
            for (int i = 2; i <= n - 2; i++) s = s + pend[i];
            push_ev((s == b) ? K_OK : K_ERR, 8'h00);
            pend.delete();
        end
    endtask

    task automatic model_stop_err();
        push_ev(K_STOP, 8'h00);
        if (pend.size() > 0) push_ev(K_ERR, 8'h00);
        pend.delete();
    endtask

    task automatic model_timeout();
        if (pend.size() > 0) push_ev(K_ERR, 8'h00);
        pend.delete();
    endtask

    // ---------------- compare process ----------------
    logic       frm_exp  = 1'b0;
    logic [7:0] data_exp = 8'h00;
    int         cyc = 0, cyc_vld = 0, cyc_err = 0;
    int         ok_seen = 0, err_seen = 0, stop_seen = 0;
    bit         frm_seen = 1'b0;
    logic [7:0] got_data[$];

    task automatic expect_ev(input int k, input string nm, output logic [7:0] v);
        ev_t e;
        v = 8'h00;
        if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: unexpected pulse, got 1 want 0", nm);
        end else begin
            e = expq.pop_front();
            check(nm, 32'(k), 32'(e.kind));
            v = e.val;
        end
    endtask

    always @(negedge clk_sys) begin
        logic [7:0] v;
        cyc++;
        if (rst) begin
            frm_exp  = 1'b0;
            data_exp = 8'h00;
        end else begin
            if (err_stop) begin
                expect_ev(K_STOP, "err_stop", v);
                stop_seen++;
            end
            if (pk_vld) begin
                expect_ev(K_DATA, "pk_vld", v);
                check("pk_data", 32'(pk_data), 32'(v));
                data_exp = v;
                frm_exp  = 1'b1;
                got_data.push_back(pk_data);
                cyc_vld = cyc;
            end
            if (pk_ok) begin
                expect_ev(K_OK, "pk_ok", v);
                frm_exp = 1'b0;
                ok_seen++;
            end
            if (pk_err) begin
                expect_ev(K_ERR, "pk_err", v);
                frm_exp = 1'b0;
                err_seen++;
                cyc_err = cyc;
            end
            if (pk_ok || pk_err) check("ok_err_excl", 32'(pk_ok & pk_err), 32'd0);
            if (pk_frm) frm_seen = 1'b1;
            check("pk_frm", 32'(pk_frm), 32'(frm_exp));
            check("pk_data_hold", 32'(pk_data), 32'(data_exp));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx_a = 1'b0;
        repeat (BIT) @(negedge clk_sys);
        for (int i = 0; i < 8; i++) begin
            rx_a = b[i];
            repeat (BIT) @(negedge clk_sys);
        end
        rx_a = stop_ok;
        repeat (BIT / 4) @(negedge clk_sys);
        if (stop_ok) model_byte(b);
        else         model_stop_err();
        repeat (BIT - BIT / 4) @(negedge clk_sys);
        rx_a = 1'b1;
        if (!stop_ok) repeat (BIT) @(negedge clk_sys);
    endtask

    task automatic send_seq(input logic [7:0] q[$], input int bad_idx);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(q[i], (i != bad_idx));
            repeat ($urandom_range(0, 7)) @(negedge clk_sys);
        end
    endtask

    task automatic drain(input string nm);
        int n;
`ifdef COMMU_RX_TMO_EN
        model_timeout();
`endif
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        repeat (20) @(negedge clk_sys);
        check(nm, 32'(expq.size()), 32'd0);
    endtask

    logic [7:0] fr[$];
    logic [7:0] good[$];
    int         ok0, err0, stop0;

    task automatic mark();
        ok0   = ok_seen;
        err0  = err_seen;
        stop0 = stop_seen;
        frm_seen = 1'b0;
        got_data.delete();
    endtask

    initial begin
        logic [7:0] want1[3];
        want1 = '{8'h11, 8'h22, 8'h33};
        good  = {8'hEB, 8'h90, 8'h05, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6E};

        repeat (4) @(negedge clk_sys);
        check("rst_pk_data", 32'(pk_data), 32'd0);
        check("rst_pk_vld", 32'(pk_vld), 32'd0);
        check("rst_pk_frm", 32'(pk_frm), 32'd0);
        check("rst_pk_ok", 32'(pk_ok), 32'd0);
        check("rst_pk_err", 32'(pk_err), 32'd0);
        check("rst_err_stop", 32'(err_stop), 32'd0);
        rst = 1'b0;
        repeat (BIT * 2) @(negedge clk_sys);

        // basic good frame
        mark();
        send_seq(good, -1);
        drain("t1_drain");
        check("t1_nbytes", 32'(got_data.size()), 32'd3);
        if (got_data.size() == 3)
            for (int i = 0; i < 3; i++) check("t1_byte", 32'(got_data[i]), 32'(want1[i]));
        check("t1_ok", 32'(ok_seen - ok0), 32'd1);
        check("t1_err", 32'(err_seen - err0), 32'd0);
        check("t1_frm_seen", 32'(frm_seen), 32'd1);

        // bad checksum then recovery
        mark();
        fr = good;
        fr[8] = 8'h6F;
        send_seq(fr, -1);
        drain("t2_drain");
        check("t2_nbytes", 32'(got_data.size()), 32'd3);
        check("t2_ok", 32'(ok_seen - ok0), 32'd0);
        check("t2_err", 32'(err_seen - err0), 32'd1);
        mark();
        send_seq(good, -1);
        drain("t2b_drain");
        check("t2b_ok", 32'(ok_seen - ok0), 32'd1);

        // foreign ID, then repeated header with LEN=0
        mark();
        fr = good;
        fr[2] = 8'h06;
        send_seq(fr, -1);
        drain("t3_drain");
        check("t3_nbytes", 32'(got_data.size()), 32'd0);
        check("t3_okerr", 32'(ok_seen - ok0 + err_seen - err0), 32'd0);
        mark();
        fr = {8'hEB, 8'hEB, 8'h90, 8'h05, 8'h00, 8'h00, 8'h05};
        send_seq(fr, -1);
        drain("t3b_drain");
        check("t3b_ok", 32'(ok_seen - ok0), 32'd1);
        check("t3b_frm_seen", 32'(frm_seen), 32'd0);

        // stop bit low on second payload byte
        mark();
        send_seq(good, 6);
        drain("t4_drain");
        check("t4_nbytes", 32'(got_data.size()), 32'd1);
        check("t4_stop", 32'(stop_seen - stop0), 32'd1);
        check("t4_err", 32'(err_seen - err0), 32'd1);
        check("t4_ok", 32'(ok_seen - ok0), 32'd0);
        mark();
        send_seq(good, -1);
        drain("t4b_drain");
        check("t4b_ok", 32'(ok_seen - ok0), 32'd1);

        // short glitch, then oversize LEN
        mark();
        rx_a = 1'b0;
        repeat (4 * BD) @(negedge clk_sys);
        rx_a = 1'b1;
        repeat (BIT * 12) @(negedge clk_sys);
        check("t5_glitch_vld", 32'(got_data.size()), 32'd0);
        fr = {8'hEB, 8'h90, 8'h05, 8'h08, 8'h01};
        send_seq(fr, -1);
        drain("t5_drain");
        check("t5_err", 32'(err_seen - err0), 32'd1);
        check("t5_stop", 32'(stop_seen - stop0), 32'd0);
        check("t5_frm_seen", 32'(frm_seen), 32'd0);

        // randomized frames
        for (int f = 0; f < 10; f++) begin
            int         len;
            logic [7:0] s;
            fr.delete();
            repeat ($urandom_range(0, 2)) fr.push_back(8'($urandom));
            fr.push_back(8'hEB);
            fr.push_back(8'h90);
            fr.push_back(($urandom_range(0, 3) == 0) ? 8'h06 : 8'h05);
            len = $urandom_range(0, 3);
            fr.push_back(8'h00);
            fr.push_back(8'(len));
            s = fr[fr.size() - 3] + 8'(len);
            for (int i = 0; i < len; i++) begin
                fr.push_back(8'($urandom));
                s = s + fr[fr.size() - 1];
            end
            fr.push_back(($urandom_range(0, 3) == 0) ? s + 8'h01 : s);
            send_seq(fr, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, fr.size() - 1)) : -1);
        end
        drain("rand_drain");

        // reset in the middle of a frame
        rst = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        pend.delete();
        repeat (BIT) @(negedge clk_sys);
        mark();
        fr = {8'hEB, 8'h90, 8'h05, 8'h00, 8'h03, 8'h11, 8'h22};
        send_seq(fr, -1);
        repeat (60) @(negedge clk_sys);
        check("rst_mid_frm_before", 32'(pk_frm), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_frm_after", 32'(pk_frm), 32'd0);
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        pend.delete();
        check("rst_mid_pending", 32'(expq.size()), 32'd0);
        repeat (BIT) @(negedge clk_sys);
        check("rst_mid_okerr", 32'(ok_seen - ok0 + err_seen - err0), 32'd0);
        mark();
        send_seq(good, -1);
        drain("rst_after_drain");
        check("rst_after_ok", 32'(ok_seen - ok0), 32'd1);

        // stalled frame
        mark();
        fr = {8'hEB, 8'h90, 8'h05, 8'h00, 8'h03, 8'hAA};
        send_seq(fr, -1);
`ifdef COMMU_RX_TMO_EN
        drain("tmo_drain");
        check("tmo_err", 32'(err_seen - err0), 32'd1);
        check("tmo_latency", 32'(cyc_err - cyc_vld), 32'(int'(TMO) - 1));
`else
        repeat (3000) @(negedge clk_sys);
        check("tmo_none_err", 32'(err_seen - err0), 32'd0);
        check("tmo_none_pending", 32'(expq.size()), 32'd0);
`endif
        check("tmo_nbytes", 32'(got_data.size()), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
